// File: rtl/jtpopeye_prio_mix.sv
// rtl/jtpopeye_prio_mix.sv - N-layer priority colour mixer with palette RAM and fade engine
//
// Purpose: picks the highest-priority opaque layer (layer 0 wins), looks its
// colour up in a runtime-writable palette, applies blanking and a frame-timed
// brightness fade, and drives registered RGB three pxl2_cen ticks later.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pxl2_cen            pixel clock enable; pipeline advances only on it
//   HB_n, VB_n          horizontal / vertical blank, active low
//   layer_idx/vld       packed per-layer colour indexes and opaque flags
//   pal_addr/din/we     palette write port {layer, index} <= {R,G,B}
//   fade_req/dir/rate   fade start pulse, direction (1 = in), frames per step - 1
//   red/green/blue      registered pixel colour
//   pxl_act             output pixel is inside the active area
//   fade_level          current brightness 0..15
//   fade_busy/done      fade in progress / one-clk completion pulse

module jtpopeye_prio_mix #(
   parameter int LAYERS = 3,
   parameter int IW     = 6,
   parameter int LSELW  = 2,
   parameter int CHW    = 3,
   parameter int FRW    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pxl2_cen,
   input  logic                   HB_n,
   input  logic                   VB_n,
   input  logic [LAYERS*IW-1:0]   layer_idx,
   input  logic [LAYERS-1:0]      layer_vld,
   input  logic [LSELW+IW-1:0]    pal_addr,
   input  logic [3*CHW-1:0]       pal_din,
   input  logic                   pal_we,
   input  logic                   fade_req,
   input  logic                   fade_dir,
   input  logic [FRW-1:0]         fade_rate,
   output logic [CHW-1:0]         red,
   output logic [CHW-1:0]         green,
   output logic [CHW-1:0]         blue,
   output logic                   pxl_act,
   output logic [3:0]             fade_level,
   output logic                   fade_busy,
   output logic                   fade_done
);

   localparam int AW = LSELW + IW;
   localparam int MW = CHW + 5;

   typedef enum logic {IDLE, STEP} state_t;

   // Palette storage (not reset)
   logic [3*CHW-1:0] pal_mem [0:(1<<AW)-1];

   // Stage A
   logic [AW-1:0]    rd_addr_q;
   logic             hit_a_q, blank_a_q;
   // Stage B
   logic [3*CHW-1:0] pal_q;
   logic             hit_b_q, blank_b_q;
   // Stage C
   logic [CHW-1:0]   red_q, green_q, blue_q;
   logic             act_q;

   // Fade engine
   state_t           state_q;
   logic [3:0]       fade_level_q, target_q;
   logic [FRW-1:0]   cnt_q;
   logic             done_q;
   logic             vb_q;
   logic             frame_tick;

   // Winner select: scanning down from the top leaves the lowest opaque layer
   logic [LSELW-1:0] win_d;
   logic [IW-1:0]    widx_d;

   always_comb begin
      win_d  = '0;
      widx_d = '0;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         if (layer_vld[i]) begin
            win_d  = LSELW'(i);
            widx_d = layer_idx[i*IW +: IW];
         end
      end
   end

   // Brightness scaling: c * (level + 1) >> 4 in CHW+5-bit intermediates
   logic [MW-1:0]  lvl_p1, mul_r, mul_g, mul_b;
   logic [CHW-1:0] sc_r, sc_g, sc_b;

   always_comb begin
      lvl_p1 = MW'(fade_level_q) + MW'(1);
      mul_r  = MW'(pal_q[3*CHW-1 -: CHW]) * lvl_p1;
      mul_g  = MW'(pal_q[2*CHW-1 -: CHW]) * lvl_p1;
      mul_b  = MW'(pal_q[CHW-1   -: CHW]) * lvl_p1;
      sc_r   = mul_r[CHW+3:4];
      sc_g   = mul_g[CHW+3:4];
      sc_b   = mul_b[CHW+3:4];
   end

   logic unused_mul;
   assign unused_mul = ^{mul_r[MW-1], mul_r[3:0], mul_g[MW-1], mul_g[3:0],
                         mul_b[MW-1], mul_b[3:0]};

   // Palette write port; a same-clk read in the pipeline block sees old data
   always_ff @(posedge clk) begin
      if (pal_we) pal_mem[pal_addr] <= pal_din;
   end

   // Pixel pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_q <= '0;
         hit_a_q   <= 1'b0;
         blank_a_q <= 1'b0;
         pal_q     <= '0;
         hit_b_q   <= 1'b0;
         blank_b_q <= 1'b0;
         red_q     <= '0;
         green_q   <= '0;
         blue_q    <= '0;
         act_q     <= 1'b0;
      end else if (pxl2_cen) begin
         rd_addr_q <= {win_d, widx_d};
         hit_a_q   <= |layer_vld;
         blank_a_q <= !(HB_n & VB_n);
         pal_q     <= pal_mem[rd_addr_q];
         hit_b_q   <= hit_a_q;
         blank_b_q <= blank_a_q;
         if (blank_b_q || !hit_b_q || fade_level_q == 4'd0) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
         end else begin
            red_q   <= sc_r;
            green_q <= sc_g;
            blue_q  <= sc_b;
         end
         act_q <= !blank_b_q;
      end
   end

   // Frame tick on VB_n falling edge, independent of pxl2_cen
   assign frame_tick = vb_q & ~VB_n;

   logic [3:0] step_lvl;
   assign step_lvl = (target_q > fade_level_q) ? fade_level_q + 4'd1
                                                : fade_level_q - 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         vb_q         <= 1'b0;
         state_q      <= IDLE;
         fade_level_q <= 4'd15;
         target_q     <= 4'd15;
         cnt_q        <= '0;
         done_q       <= 1'b0;
      end else begin
         vb_q   <= VB_n;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fade_req) begin
                  if (fade_level_q == (fade_dir ? 4'd15 : 4'd0)) begin
                     done_q <= 1'b1;
                  end else begin
                     target_q <= fade_dir ? 4'd15 : 4'd0;
                     cnt_q    <= '0;
                     state_q  <= STEP;
                  end
               end
            end
            STEP: begin
               if (frame_tick) begin
                  if (cnt_q == fade_rate) begin
                     cnt_q        <= '0;
                     fade_level_q <= step_lvl;
                     if (step_lvl == target_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign red        = red_q;
   assign green      = green_q;
   assign blue       = blue_q;
   assign pxl_act    = act_q;
   assign fade_level = fade_level_q;
   assign fade_busy  = (state_q == STEP);
   assign fade_done  = done_q;

endmodule

// File: tb/tb_jtpopeye_prio_mix.sv
// tb/tb_jtpopeye_prio_mix.sv - scoreboard bench for jtpopeye_prio_mix
module tb_jtpopeye_prio_mix;

   logic        clk = 1'b0;
   logic        rst, pxl2_cen, HB_n, VB_n;
   logic [17:0] layer_idx;
   logic [2:0]  layer_vld;
   logic [7:0]  pal_addr;
   logic [8:0]  pal_din;
   logic        pal_we, fade_req, fade_dir;
   logic [3:0]  fade_rate;
   logic [2:0]  red, green, blue;
   logic        pxl_act;
   logic [3:0]  fade_level;
   logic        fade_busy, fade_done;

   jtpopeye_prio_mix dut (
      .clk(clk), .rst(rst), .pxl2_cen(pxl2_cen), .HB_n(HB_n), .VB_n(VB_n),
      .layer_idx(layer_idx), .layer_vld(layer_vld),
      .pal_addr(pal_addr), .pal_din(pal_din), .pal_we(pal_we),
      .fade_req(fade_req), .fade_dir(fade_dir), .fade_rate(fade_rate),
      .red(red), .green(green), .blue(blue), .pxl_act(pxl_act),
      .fade_level(fade_level), .fade_busy(fade_busy), .fade_done(fade_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] rgb;
      logic       act;
      int         due;
   } exp_t;

   exp_t        sb[$];
   logic [8:0]  pal_m [0:255];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          tick_cnt = 0;
   int          exp_level = 15;
   int          done_cnt = 0;
   int          busy_cnt = 0;

   localparam logic [17:0] IDX5 = {6'd5, 6'd5, 6'd5};
   localparam logic [17:0] IDX9 = {6'd5, 6'd5, 6'd9};

   always @(negedge clk) begin
      if (fade_done) done_cnt++;
      if (fade_busy) busy_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] model(input logic [2:0] vld, input logic [17:0] idx,
                                         input logic hb, input int lvl);
      int w = -1;
      logic [8:0] c;
      logic [7:0] a;
      int r, g, b;
      for (int i = 0; i < 3; i++) if (vld[i] && w < 0) w = i;
      if (w < 0 || !hb || lvl == 0) return 9'd0;
      a = {w[1:0], idx[w*6 +: 6]};
      c = pal_m[a];
      r = (int'(c[8:6]) * (lvl + 1)) / 16;
      g = (int'(c[5:3]) * (lvl + 1)) / 16;
      b = (int'(c[2:0]) * (lvl + 1)) / 16;
      return {r[2:0], g[2:0], b[2:0]};
   endfunction

   task automatic cen_edge();
      exp_t e;
      pxl2_cen = 1'b1;
      @(posedge clk); #1;
      pxl2_cen = 1'b0;
      tick_cnt++;
      while (sb.size() > 0 && sb[0].due == tick_cnt) begin
         e = sb.pop_front();
         check("rgb", {red, green, blue}, e.rgb);
         check("act", pxl_act, e.act);
      end
   endtask

   task automatic pix(input logic [2:0] vld, input logic [17:0] idx, input logic hb,
                      input int gap, input logic we, input logic [7:0] wa, input logic [8:0] wd);
      exp_t e;
      logic [9:0] hold;
      layer_vld = vld; layer_idx = idx; HB_n = hb; VB_n = 1'b1;
      if (we) begin
         pal_we = 1'b1; pal_addr = wa; pal_din = wd;
         pal_m[wa] = wd;
      end
      e.rgb = model(vld, idx, hb, exp_level);
      e.act = hb;
      e.due = tick_cnt + 3;
      sb.push_back(e);
      cen_edge();
      pal_we = 1'b0;
      for (int g = 1; g < gap; g++) begin
         hold = {red, green, blue, pxl_act};
         layer_vld = 3'($urandom);
         layer_idx = 18'($urandom);
         HB_n = 1'($urandom);
         @(posedge clk); #1;
         check("hold", {red, green, blue, pxl_act}, hold);
      end
   endtask

   task automatic flush();
      layer_vld = 3'd0; HB_n = 1'b1;
      repeat (3) cen_edge();
      check("sb_empty", sb.size(), 0);
   endtask

   task automatic wr_pal(input logic [7:0] a, input logic [8:0] d);
      pal_we = 1'b1; pal_addr = a; pal_din = d;
      @(posedge clk); #1;
      pal_we = 1'b0;
      pal_m[a] = d;
   endtask

   task automatic frame();
      VB_n = 1'b0;
      @(posedge clk); #1;
      VB_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic req(input logic dir);
      fade_dir = dir; fade_req = 1'b1;
      @(posedge clk); #1;
      fade_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int d0, b0;
      rst = 1'b1; pxl2_cen = 1'b0; HB_n = 1'b1; VB_n = 1'b1;
      layer_idx = '0; layer_vld = '0; pal_addr = '0; pal_din = '0; pal_we = 1'b0;
      fade_req = 1'b0; fade_dir = 1'b0; fade_rate = 4'd0;
      for (int i = 0; i < 256; i++) pal_m[i] = 9'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb", {red, green, blue}, 9'd0);
      check("rst_act", pxl_act, 1'b0);
      check("rst_lvl", fade_level, 4'd15);
      check("rst_busy", fade_busy, 1'b0);
      check("rst_done", fade_done, 1'b0);
      rst = 1'b0;

      // Priority
      wr_pal({2'd0, 6'd5}, 9'h1FF);
      wr_pal({2'd1, 6'd5}, 9'h0C3);
      wr_pal({2'd2, 6'd5}, 9'h038);
      wr_pal({2'd0, 6'd9}, 9'h111);
      pix(3'b111, IDX5, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      pix(3'b110, IDX5, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      pix(3'b100, IDX5, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      // Transparency and blanking
      pix(3'b000, IDX5, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      pix(3'b111, IDX5, 1'b0, 1, 1'b0, 8'd0, 9'd0);
      pix(3'b011, IDX5, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      flush();
      check("prio_c_lit", model(3'b100, IDX5, 1'b1, 15), 9'o070);

      // Cen gating
      pix(3'b110, IDX5, 1'b1, 4, 1'b0, 8'd0, 9'd0);
      pix(3'b111, IDX5, 1'b1, 4, 1'b0, 8'd0, 9'd0);
      pix(3'b100, IDX5, 1'b0, 4, 1'b0, 8'd0, 9'd0);
      pix(3'b100, IDX5, 1'b1, 4, 1'b0, 8'd0, 9'd0);
      pix(3'b010, IDX5, 1'b1, 4, 1'b0, 8'd0, 9'd0);
      flush();

      // Palette collision: second write lands on the clk the first pixel's read happens
      pix(3'b001, IDX9, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      pix(3'b001, IDX9, 1'b1, 1, 1'b1, {2'd0, 6'd9}, 9'h0AA);
      pix(3'b001, IDX9, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      flush();

      // Fade out
      fade_rate = 4'd1;
      d0 = done_cnt;
      req(1'b0);
      check("fo_busy", fade_busy, 1'b1);
      frame();
      check("fo_lvl_f1", fade_level, 4'd15);
      frame();
      check("fo_lvl_f2", fade_level, 4'd14);
      repeat (27) frame();
      check("fo_lvl_f29", fade_level, 4'd1);
      check("fo_busy29", fade_busy, 1'b1);
      frame();
      check("fo_lvl_f30", fade_level, 4'd0);
      check("fo_idle", fade_busy, 1'b0);
      check("fo_done_cnt", done_cnt - d0, 1);
      exp_level = 0;
      pix(3'b001, IDX5, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      flush();

      // Fade in to level 7, check channel scaling
      fade_rate = 4'd0;
      req(1'b1);
      repeat (7) frame();
      check("fi_lvl7", fade_level, 4'd7);
      exp_level = 7;
      pix(3'b001, IDX5, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      pix(3'b010, IDX5, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      flush();
      check("lvl7_lit", model(3'b001, IDX5, 1'b1, 7), 9'o333);

      // Second request mid-fade ignored
      d0 = done_cnt;
      req(1'b0);
      frame();
      check("mid_lvl8", fade_level, 4'd8);
      check("mid_busy", fade_busy, 1'b1);
      frame();
      check("mid_lvl9", fade_level, 4'd9);

      // Reset mid-fade
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_level = 15;
      check("rst_mid_lvl", fade_level, 4'd15);
      check("rst_mid_busy", fade_busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_mid_nodone", done_cnt - d0, 0);

      // Request at target already reached
      d0 = done_cnt;
      b0 = busy_cnt;
      req(1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("noop_done", done_cnt - d0, 1);
      check("noop_busy", busy_cnt - b0, 0);
      check("noop_lvl", fade_level, 4'd15);

      pix(3'b111, IDX5, 1'b1, 1, 1'b0, 8'd0, 9'd0);
      flush();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jtpopeye_prio_mix.md
Name: jtpopeye_prio_mix

Overview:
- Parametrised layer colour mixer, the successor to the fixed three-layer Popeye mixer.
- Takes N tile/sprite layers, each with a colour index and a valid flag, and selects the highest-priority opaque layer.
- Looks the winner up in a shared, runtime-writable palette RAM.
- Applies blanking and a frame-timed brightness fade engine, then drives final RGB to the video output stage.

Parameters:
LAYERS, 3, number of input layers; layer 0 is highest priority
IW, 6, colour index width per layer
LSELW, 2, layer-select width; 2^LSELW >= LAYERS
CHW, 3, bits per RGB channel
FRW, 4, width of the fade frame-rate divider

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pxl2_cen  in  1  pixel clock enable; all pipeline stages advance only on it
HB_n  in  1  horizontal blank, active low
VB_n  in  1  vertical blank, active low
layer_idx  in  LAYERS*IW  packed indexes; layer i at [i*IW +: IW]
layer_vld  in  LAYERS  per-layer opaque flag
pal_addr  in  LSELW+IW  palette write address {layer, index}
pal_din  in  3*CHW  palette write data {R,G,B}
pal_we  in  1  palette write strobe, independent of pxl2_cen
fade_req  in  1  one-clk pulse starting a fade
fade_dir  in  1  0 = fade out to black, 1 = fade in to full
fade_rate  in  FRW  frames per brightness step, minus 1
red, green, blue  out  CHW each  registered pixel colour
pxl_act  out  1  output pixel is inside the active area
fade_level  out  4  current brightness, 0..15
fade_busy  out  1  fade in progress
fade_done  out  1  one-clk pulse when a fade completes

Behaviour:
- Reset state: red, green and blue = 0; pxl_act = 0; fade_level = 15; fade_busy = 0; fade_done = 0; fade FSM in IDLE; frame counter = 0; all pipeline registers cleared. Palette contents are not reset.
- Stage A (pxl2_cen tick n):
  - Winner = lowest i with layer_vld[i] = 1.
  - Register the palette read address {i, layer_idx[i]} and hit = |layer_vld.
  - Register blank = !(HB_n & VB_n).
- Stage B (tick n+1): synchronous palette read; hit and blank are delayed alongside it.
- Stage C (tick n+2): output registered.
  - If blank, or no hit: output RGB = 0.
  - Otherwise: each channel = (c*(fade_level+1)) >> 4, computed in CHW+5-bit intermediates; fade_level = 0 forces 0.
  - pxl_act = !blank.
- Latency: exactly 3 pxl2_cen ticks from input sample to output. Outputs hold their value between ticks.
- Palette RAM:
  - Depth 2^(LSELW+IW), written on any clk with pal_we.
  - Read-during-write to the same address returns the old data.
  - Addresses for layer numbers >= LAYERS are writable but never read.
- Frame tick: one-clk strobe on each falling edge of VB_n, detected with a registered copy of VB_n. It is independent of pxl2_cen.
- Fade FSM (IDLE, STEP):
  - IDLE + fade_req: target = fade_dir ? 15 : 0. If fade_level already equals target, pulse fade_done and stay in IDLE. Otherwise clear the frame counter and go to STEP.
  - STEP, on a frame tick:
    - If counter == fade_rate: move fade_level one step toward target and clear the counter.
    - Otherwise: increment the counter.
    - When fade_level reaches target: go to IDLE and pulse fade_done on the following clk.
  - fade_busy = (state == STEP).
  - fade_req while in STEP is ignored.
  - fade_rate is sampled continuously; a change mid-fade takes effect at the next comparison.
- fade_level changes take effect at stage C, so a level change mid-line is allowed.
- rst mid-fade: the FSM returns immediately to IDLE with fade_level = 15; no fade_done pulse.

Test Plan:
1. Priority
   - Stimulus: write palette {0,5} = 0x1FF, {1,5} = 0x0C3, {2,5} = 0x038; all layers index 5, HB_n = VB_n = 1; vld = 111, then 110, then 100.
   - Required: three ticks after each sample, {R,G,B} = 7/7/7, then 3/0/3, then 0/7/0.
2. Transparency and blanking
   - Stimulus: vld = 000.
   - Required: RGB = 0 with pxl_act = 1.
   - Stimulus: vld = 111 with HB_n = 0.
   - Required: RGB = 0 with pxl_act = 0, both with exactly 3-tick latency.
3. Cen gating
   - Stimulus: pxl2_cen every 4th clk, with changing inputs between enables.
   - Required: outputs change only on enable edges and never reflect unsampled values.
4. Fade out
   - Stimulus: fade_rate = 1; fade_req with fade_dir = 0; 30 VB_n falling edges.
   - Required: level steps 15→14 after 2 frames, then reaches 0 after 30 frames; fade_done pulses once; channel 7 at level 7 outputs 3.
5. Edge cases
   - Stimulus: fade_req at level 15 with fade_dir = 1.
   - Required: immediate fade_done pulse; fade_busy never asserts.
   - Stimulus: a second fade_req mid-fade.
   - Required: ignored.
   - Stimulus: rst mid-fade.
   - Required: level = 15, IDLE, no fade_done pulse.
6. Palette write collision
   - Stimulus: pal_we to the address being read on the same clk as a pxl2_cen tick.
   - Required: old colour is output; the new colour appears on the next sample of that address.
